// File: rtl/sync_down_counter_if.sv
// Groups the sync_down_counter control/status signals into one bundle.
// The slave modport is the counter; the master modport is whoever drives it.
interface sync_down_counter_if #(
  parameter int WIDTH = 3
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             auto_reload;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             busy;
  logic             done;

  modport master (
    output load, load_val, en, auto_reload,
    input  q, tc, busy, done
  );

  modport slave (
    input  load, load_val, en, auto_reload,
    output q, tc, busy, done
  );
endinterface

// File: rtl/sync_down_counter.sv
// Loadable down counter with IDLE/RUN/DONE sequencing and a one-cycle terminal-count pulse.
// Define SYNC_DOWN_COUNTER_RELOAD_EN to add auto-reload of the last loaded value at terminal count.
module sync_down_counter #(
  parameter int WIDTH = 3
) (
  input  logic                clk,
  input  logic                reset,
  sync_down_counter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic             r_tc;

  state_t           w_nextState;
  logic [WIDTH-1:0] w_nextQ;
  logic             w_nextTc;
  logic             w_atTerminal;

`ifdef SYNC_DOWN_COUNTER_RELOAD_EN
  logic [WIDTH-1:0] r_reload;
  logic [WIDTH-1:0] w_nextReload;
`endif

  assign w_atTerminal = (r_q == WIDTH'(1));

  // Load wins over everything; counting only happens in RUN while enabled.
  always_comb begin
    w_nextState = r_state;
    w_nextQ     = r_q;
    w_nextTc    = 1'b0;
`ifdef SYNC_DOWN_COUNTER_RELOAD_EN
    w_nextReload = r_reload;
`endif
    if (bus.load) begin
      w_nextQ     = bus.load_val;
      w_nextState = (bus.load_val != '0) ? RUN : IDLE;
`ifdef SYNC_DOWN_COUNTER_RELOAD_EN
      w_nextReload = bus.load_val;
`endif
    end else if (r_state == RUN && bus.en) begin
      if (r_q > WIDTH'(1)) begin
        w_nextQ = r_q - WIDTH'(1);
      end else if (w_atTerminal) begin
        w_nextTc = 1'b1;
`ifdef SYNC_DOWN_COUNTER_RELOAD_EN
        if (bus.auto_reload) begin
          w_nextQ = r_reload;
        end else begin
          w_nextQ     = '0;
          w_nextState = DONE;
        end
`else
        w_nextQ     = '0;
        w_nextState = DONE;
`endif
      end else begin
        // A zero count in RUN is unreachable; park in DONE rather than wrap.
        w_nextState = DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_tc    <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_q     <= w_nextQ;
      r_tc    <= w_nextTc;
    end
  end

`ifdef SYNC_DOWN_COUNTER_RELOAD_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_reload <= '0;
    end else begin
      r_reload <= w_nextReload;
    end
  end
`endif

  assign bus.q    = r_q;
  assign bus.tc   = r_tc;
  assign bus.busy = (r_state == RUN);
  assign bus.done = (r_state == DONE);

endmodule

// File: tb/tb_sync_down_counter.sv
// Table-driven bench for sync_down_counter with a queue scoreboard of expected outputs.
// Auto-reload expectations follow SYNC_DOWN_COUNTER_RELOAD_EN.
module tb_sync_down_counter;

  localparam int WIDTH = 3;

  typedef struct {
    logic             rstN;
    logic             ld;
    logic [WIDTH-1:0] ldVal;
    logic             en;
    logic             ar;
    logic [WIDTH-1:0] expQ;
    logic             expTc;
    logic             expBusy;
    logic             expDone;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  vec_t table_q[$];
  vec_t expQueue[$];

  sync_down_counter_if #(.WIDTH(WIDTH)) cntIf ();

  sync_down_counter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (cntIf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkVec(input logic rstN, input logic ld, input logic [WIDTH-1:0] ldVal,
                                 input logic en, input logic ar, input logic [WIDTH-1:0] q,
                                 input logic tc, input logic busy, input logic done);
    vec_t v;
    v.rstN = rstN; v.ld = ld; v.ldVal = ldVal; v.en = en; v.ar = ar;
    v.expQ = q; v.expTc = tc; v.expBusy = busy; v.expDone = done;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    reset             = v.rstN;
    cntIf.load        = v.ld;
    cntIf.load_val    = v.ldVal;
    cntIf.en          = v.en;
    cntIf.auto_reload = v.ar;
    expQueue.push_back(v);
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string tag, input string field, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s.%s: actual=%0d required=%0d", tag, field, act, req);
    end
  endtask

  task automatic checkOutput(input string tag);
    vec_t e;
    if (expQueue.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s.scoreboard: actual=empty required=entry", tag);
    end else begin
      e = expQueue.pop_front();
      cmp(tag, "q", cntIf.q, e.expQ);
      cmp(tag, "tc", WIDTH'(cntIf.tc), WIDTH'(e.expTc));
      cmp(tag, "busy", WIDTH'(cntIf.busy), WIDTH'(e.expBusy));
      cmp(tag, "done", WIDTH'(cntIf.done), WIDTH'(e.expDone));
    end
  endtask

  task automatic runVec(input vec_t v, input string tag);
    applyStimulus(v);
    checkOutput(tag);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    cntIf.load = 1'b0;
    cntIf.load_val = '0;
    cntIf.en = 1'b0;
    cntIf.auto_reload = 1'b0;

    //                    rstN  ld   val  en   ar   q    tc   busy done
    // Reset two cycles, load 5, count down to terminal, then sit in DONE.
    table_q.push_back(mkVec(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
    table_q.push_back(mkVec(1'b0, 1'b1, 3'd7, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
    table_q.push_back(mkVec(1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 3'd5, 1'b0, 1'b1, 1'b0));
    table_q.push_back(mkVec(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0));
    table_q.push_back(mkVec(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0));
    table_q.push_back(mkVec(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0));
    table_q.push_back(mkVec(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0));
    table_q.push_back(mkVec(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1));
    table_q.push_back(mkVec(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1));
    table_q.push_back(mkVec(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1));
    // Load from DONE, reach 3, then enable pattern 1,0,0,1.
    table_q.push_back(mkVec(1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0));
    table_q.push_back(mkVec(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0));
    table_q.push_back(mkVec(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0));
    table_q.push_back(mkVec(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0));
    table_q.push_back(mkVec(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0));
    table_q.push_back(mkVec(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0));
    // Load beats terminal count at q=1.
    table_q.push_back(mkVec(1'b1, 1'b1, 3'd6, 1'b1, 1'b0, 3'd6, 1'b0, 1'b1, 1'b0));
    table_q.push_back(mkVec(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 3'd5, 1'b0, 1'b1, 1'b0));
    table_q.push_back(mkVec(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0));
    table_q.push_back(mkVec(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0));
    table_q.push_back(mkVec(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0));
    // Reset mid-count at q=2, then first released edge stays IDLE.
    table_q.push_back(mkVec(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
    table_q.push_back(mkVec(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
    // Zero load stays IDLE and never wraps.
    table_q.push_back(mkVec(1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
    for (int k = 0; k < 4; k++)
      table_q.push_back(mkVec(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
    // Full-scale load.
    table_q.push_back(mkVec(1'b1, 1'b1, 3'd7, 1'b1, 1'b0, 3'd7, 1'b0, 1'b1, 1'b0));
    table_q.push_back(mkVec(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 3'd6, 1'b0, 1'b1, 1'b0));

    for (int i = 0; i < table_q.size(); i++)
      runVec(table_q[i], $sformatf("vec%0d", i));

    // Terminal count from q=1 with reset asserted: abandoned, no tc pulse.
    runVec(mkVec(1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0), "midRst0");
    runVec(mkVec(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0), "midRst1");
    runVec(mkVec(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0), "midRst2");

    // Auto-reload sequence: load 3 and keep counting with auto_reload high.
    runVec(mkVec(1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0), "arLoad");
    runVec(mkVec(1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0), "ar1");
    runVec(mkVec(1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0), "ar2");
`ifdef SYNC_DOWN_COUNTER_RELOAD_EN
    runVec(mkVec(1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0), "ar3");
    runVec(mkVec(1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0), "ar4");
    runVec(mkVec(1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0), "ar5");
    runVec(mkVec(1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0), "ar6");
`else
    runVec(mkVec(1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1), "ar3");
    runVec(mkVec(1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1), "ar4");
`endif

    if (expQueue.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboardDrain: actual=%0d required=0", expQueue.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_down_counter.md
SYNC_DOWN_COUNTER -- requirements
Module: sync_down_counter

Interface
REQ-001 SHALL provide parameter WIDTH, default 3, the count register width in bits (legal range 2..16).
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates occur on its rising edge.
REQ-003 SHALL provide port reset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 SHALL provide port load  input  1  load request; when high, q takes load_val at the next edge.
REQ-005 SHALL provide port load_val  input  WIDTH  start value for the countdown.
REQ-006 SHALL provide port en  input  1  count enable; one decrement per edge while high in RUN.
REQ-007 SHALL provide port auto_reload  input  1  reload-on-terminal request; honoured only per REQ-024.
REQ-008 SHALL provide port q  output  WIDTH  current count, registered.
REQ-009 SHALL provide port tc  output  1  terminal-count pulse, registered, high for exactly one cycle.
REQ-010 SHALL provide port busy  output  1  high while in RUN.
REQ-011 SHALL provide port done  output  1  high while in DONE.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, RUN, DONE; busy = (state==RUN) and done = (state==DONE), both decoded from registered state.
REQ-013 SHALL, on load=1 in any state, set q=load_val and reload_reg=load_val; next state RUN if load_val!=0, else IDLE; tc=0 that cycle.
REQ-014 SHALL give load priority over en, terminal-count handling, and auto-reload in the same cycle.
REQ-015 SHALL, in RUN with en=1, load=0, q>1, set q=q-1 and remain in RUN.
REQ-016 SHALL, in RUN with en=1, load=0, q==1 (terminal), set tc=1 on the following cycle and apply REQ-017 or REQ-024.
REQ-017 SHALL, at terminal without reload, set q=0 and move to DONE.
REQ-018 SHALL, in RUN with en=0, hold q and state; tc=0.
REQ-019 SHALL, in IDLE or DONE without load, hold q, ignore en, and keep tc=0.
REQ-020 SHALL never decrement below 0 and never wrap from 0 to 2^WIDTH-1.
REQ-021 SHALL have a latency of one clk edge from an input change to the corresponding q/tc/busy/done change.

Reset
REQ-022 SHALL, when reset=0 at a rising edge, force q=0, reload_reg=0, tc=0, and state IDLE (busy=0, done=0), overriding load and en.
REQ-023 SHALL, on reset mid-count, abandon the count without a tc pulse; the first edge with reset=1 then follows normal rules.

Configuration
REQ-024 SHALL, with macro SYNC_DOWN_COUNTER_RELOAD_EN defined and auto_reload=1 at terminal, set q=reload_reg, stay in RUN, and pulse tc; q never reads 0 in that case.
REQ-025 SHALL, with SYNC_DOWN_COUNTER_RELOAD_EN undefined, ignore auto_reload, build no reload_reg logic, and always apply REQ-017 at terminal; load behaviour is otherwise unchanged.

Verification
REQ-026 SHALL cover: reset=0 for 2 cycles, then load=1 with load_val=5, then en=1 -> q steps 5,4,3,2,1,0; tc high for one cycle coincident with q=0; done=1, busy=0 thereafter.
REQ-027 SHALL cover: RUN at q=3, en toggled 1,0,0,1 -> q sequence 2,2,2,1; tc stays 0.
REQ-028 SHALL cover: load_val=0 with load=1 -> q=0, state IDLE, tc=0; en=1 for 4 cycles -> q stays 0.
REQ-029 SHALL cover: q=1, en=1, load=1 with load_val=6 in the same cycle -> q=6, busy=1, tc=0.
REQ-030 SHALL cover: reset=0 asserted at q=2 during RUN -> next edge q=0, busy=0, done=0, tc=0.
REQ-031 SHALL cover, macro defined: load_val=3 with auto_reload=1 and en=1 -> q cycles 3,2,1,3,2,1 with tc pulsing at each 1->3 transition; with macro undefined, the same stimulus -> q=3,2,1,0, then DONE.
